// File: rtl/seq_reg_file_if.sv
// Decode/write-back side bundle of the sequential Y86-64 register file:
// read indices and data, write-back ports, condition codes and debug read.
interface seq_reg_file_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [ADDR_W-1:0] dst_a;
    logic [DATA_W-1:0] dst_val_a;
    logic [ADDR_W-1:0] dst_b;
    logic [DATA_W-1:0] dst_val_b;
    logic              cc_we;
    logic [2:0]        cc_in;
    logic [2:0]        cc_out;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_val;
    logic              wr_collision;

    modport master (
        output src_a, src_b, dst_a, dst_val_a, dst_b, dst_val_b,
               cc_we, cc_in, dbg_addr,
        input  val_a, val_b, cc_out, dbg_val, wr_collision
    );

    modport slave (
        input  src_a, src_b, dst_a, dst_val_a, dst_b, dst_val_b,
               cc_we, cc_in, dbg_addr,
        output val_a, val_b, cc_out, dbg_val, wr_collision
    );
endinterface

// File: rtl/seq_reg_file.sv
// Y86-64 register file: 2**ADDR_W-1 registers plus RNONE, two combinational
// reads, two clocked writes (port B wins collisions), CC register, debug read.
module seq_reg_file #(
    parameter int                DATA_W  = 64,
    parameter int                ADDR_W  = 4,
    parameter int                BYPASS  = 0,
    parameter int                SP_IDX  = 4,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input logic           clk,
    input logic           reset,
    seq_reg_file_if.slave rf
);
    localparam int                NREG  = (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] RNONE = '1;

    if (SP_IDX < 0 || SP_IDX >= NREG) begin : g_sp_idx_illegal
        $error("seq_reg_file: SP_IDX must be a real register index, not RNONE");
    end

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [2:0]        cc_q;
    logic              coll_q;
    logic              we_a;
    logic              we_b;
    logic              coll_d;
    logic              byp_en;
    logic [DATA_W-1:0] sto_a;
    logic [DATA_W-1:0] sto_b;

    assign we_a   = (rf.dst_a != RNONE);
    assign we_b   = (rf.dst_b != RNONE);
    assign coll_d = we_a && we_b && (rf.dst_a == rf.dst_b);
    // Writes are inhibited while reset is held, so nothing may be forwarded then.
    assign byp_en = (BYPASS != 0) && reset;

    // NOTE: every regs_d entry gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we_a && rf.dst_a == ADDR_W'(i)) regs_d[i] = rf.dst_val_a;
            // Port B applied last: it wins a same-register collision (popq %rsp).
            if (we_b && rf.dst_b == ADDR_W'(i)) regs_d[i] = rf.dst_val_b;
        end
    end

    // NOTE: the bank is built from flops, not a RAM macro, because every entry
    // has a defined reset value that must appear without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: state uses non-blocking assignment so all flops update
                // together from pre-edge values.
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            cc_q   <= 3'b100;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            if (rf.cc_we) cc_q <= rf.cc_in;
            if (coll_d)   coll_q <= 1'b1;
        end
    end

    always_comb begin
        sto_a      = '0;
        sto_b      = '0;
        rf.dbg_val = '0;
        if (rf.src_a    != RNONE) sto_a      = regs_q[rf.src_a];
        if (rf.src_b    != RNONE) sto_b      = regs_q[rf.src_b];
        if (rf.dbg_addr != RNONE) rf.dbg_val = regs_q[rf.dbg_addr];
    end

    always_comb begin
        rf.val_a = sto_a;
        rf.val_b = sto_b;
        if (byp_en && we_a && rf.src_a == rf.dst_a) rf.val_a = rf.dst_val_a;
        if (byp_en && we_b && rf.src_a == rf.dst_b) rf.val_a = rf.dst_val_b;
        if (byp_en && we_a && rf.src_b == rf.dst_a) rf.val_b = rf.dst_val_a;
        if (byp_en && we_b && rf.src_b == rf.dst_b) rf.val_b = rf.dst_val_b;
    end

    assign rf.cc_out       = cc_q;
    assign rf.wr_collision = coll_q;
endmodule
